trap_sequencer: RTL
===================

// Module: trap_sequencer
// PURPOSE
// - Sequences trap entry and trap return for csr_regfile.
// - Arbitrates synchronous exceptions, MRET/SRET requests and enabled interrupts (MEI, MTI, SEI, STI).
// - Drains the pipeline for interrupts, pulses exception_pending/m_cause/pc_exc/m_ret/s_ret into csr_regfile for one cycle, then redirects fetch to the captured epc.
// - Sits between the execute/commit stage, csr_regfile and the front end.
// PARAMETERS
// - XLEN       32  datapath width
// - DRAIN_MAX  15  max DRAIN cycles before a forced commit; 4-bit counter, legal 1..15
// PORTS
// - clk             in   1     clock
// - rst             in   1     reset. One clock; reset is synchronous and active-high.
// - exc_valid       in   1     committing instruction raised a synchronous exception
// - exc_cause       in   5     exception code (bit31=0 cause)
// - exc_pc          in   XLEN  pc of faulting instruction
// - retire_pc       in   XLEN  pc of next instruction to execute (interrupt epc)
// - m_ret_req       in   1     MRET at commit
// - s_ret_req       in   1     SRET at commit
// - pipe_empty      in   1     no instruction in flight behind commit
// - m_eie, m_tie, s_eie, s_tie  in  1 each  gated enables from csr_regfile
// - m_interrupt, s_interrupt, m_timer, s_timer  in  1 each  pending lines
// - epc             in   XLEN  csr_regfile epc (vector or xepc)
// - exception_pending  out  1     to csr_regfile; 1-cycle pulse in COMMIT
// - m_cause         out  XLEN  cause; valid with exception_pending
// - pc_exc          out  XLEN  trap pc; valid with exception_pending
// - m_ret, s_ret    out  1     return strobes, only with exception_pending
// - flush           out  1     kill younger instructions; 1 cycle in COMMIT
// - stall           out  1     freeze front end; high in DRAIN, COMMIT, REDIRECT
// - redirect_valid  out  1     1-cycle pulse in REDIRECT
// - redirect_pc     out  XLEN  registered fetch target
// - busy            out  1     state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; latches and drain counter 0; overrides any state.
// - States: IDLE -> (DRAIN) -> COMMIT -> REDIRECT -> IDLE. Each of COMMIT and REDIRECT lasts exactly one cycle.
// - IDLE priority: exc_valid > m_ret_req > s_ret_req > MEI(m_interrupt&m_eie) > MTI(m_timer&m_tie) > SEI(s_interrupt&s_eie) > STI(s_timer&s_tie).
// - IDLE exception: latch cause = {1'b0, 26'b0, exc_cause} and pc = exc_pc; go to COMMIT.
// - IDLE MRET/SRET: latch the ret kind; go to COMMIT; cause is unchanged.
// - IDLE interrupt: latch cause = {1'b1, code}, with code MEI=11, MTI=7, SEI=9, STI=5; clear the drain counter; go to DRAIN.
// - DRAIN: the counter increments each cycle.
//   - exc_valid: replace the latch with the exception; go to COMMIT. The interrupt is dropped; its level is re-sampled later.
//   - Otherwise, pipe_empty or counter == DRAIN_MAX-1: latch pc = retire_pc; go to COMMIT.
// - COMMIT: exception_pending=1 and flush=1.
//   - m_cause and pc_exc are driven from the latches.
//   - For a ret, m_ret or s_ret=1, m_cause=0 and pc_exc=0.
//   - At the clock edge, capture the epc input into redirect_pc. csr_regfile's epc is combinational on m_ret/s_ret, so the capture yields mepc/sepc for a return and mtvec otherwise.
// - REDIRECT: redirect_valid=1 with the captured redirect_pc. All request inputs are ignored.
// - Back-to-back traps: a request present in the cycle after REDIRECT is accepted from IDLE; there is at least 1 IDLE cycle between traps.
// - m_ret_req and s_ret_req together: MRET wins and s_ret stays 0.
// - All outputs are registered, except busy and stall, which decode state.
// CONFIGURATION
// - TRAP_SEQ_PERF_EN defined:
//   - Adds outputs trap_count[31:0] and irq_count[31:0].
//   - On every COMMIT that is not a ret, trap_count increments; irq_count also increments when cause bit31=1.
//   - Both counters reset to 0 and wrap 0xFFFFFFFF -> 0.
// - TRAP_SEQ_PERF_EN undefined: neither port nor counter exists; behaviour is otherwise identical.
// TESTING
// - exc_valid=1, exc_cause=2, exc_pc=0x100, epc=0x80 -> next cycle exception_pending=1, m_cause=0x2, pc_exc=0x100, flush=1; following cycle redirect_valid=1, redirect_pc=0x80.
// - m_timer=1, m_tie=1, retire_pc=0x200, pipe_empty=0 for 3 cycles then 1 -> DRAIN with stall; COMMIT m_cause=0x80000007, pc_exc=0x200.
// - m_interrupt and s_timer both enabled and pending -> m_cause=0x8000000B; the STI request is ignored for this trap.
// - Interrupt pending, pipe_empty held 0 -> COMMIT forced exactly DRAIN_MAX cycles after DRAIN entry.
// - DRAIN with exc_valid=1, exc_cause=5 -> m_cause=0x5 and pc_exc=exc_pc (the interrupt is dropped).
// - m_ret_req=1, epc=0x344 in COMMIT -> exception_pending=1, m_ret=1, m_cause=0; redirect_pc=0x344.
// - rst=1 asserted while in DRAIN -> next cycle IDLE, busy=0, stall=0; with PERF_EN, 3 traps then a ret -> trap_count=3.

Source files
------------

// File: rtl/trap_sequencer.sv
// ============================================================================
// Module   : trap_sequencer
// Purpose  : Sequences trap entry and trap return for csr_regfile. It
//            arbitrates synchronous exceptions, MRET/SRET requests and
//            enabled interrupts (MEI, MTI, SEI, STI). Interrupts first drain
//            the pipeline. The block then pulses the trap information into
//            csr_regfile for one cycle and redirects fetch to the captured
//            epc.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN       datapath width (default 32)
//   DRAIN_MAX  max DRAIN cycles before a forced commit (4-bit, legal 1..15)
// Optional build macro
//   TRAP_SEQ_PERF_EN  adds the trap_count / irq_count performance counters
// Ports
//   clk, rst            clock, synchronous active-high reset
//   exc_valid/cause/pc  synchronous exception from commit
//   retire_pc           pc of next instruction (interrupt epc)
//   m_ret_req/s_ret_req MRET / SRET at commit
//   pipe_empty          nothing in flight behind commit
//   m_eie..s_tie        interrupt enables from csr_regfile
//   m_interrupt..s_timer pending interrupt lines
//   epc                 csr_regfile epc (vector or xepc)
//   exception_pending, m_cause, pc_exc, m_ret, s_ret  one-cycle trap pulse
//   flush, stall        pipeline control
//   redirect_valid/pc   fetch redirect
//   busy                sequencer not idle
//   trap_count/irq_count (TRAP_SEQ_PERF_EN only) performance counters
// ============================================================================
`default_nettype none

module trap_sequencer #(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] retire_pc,
    input  logic            m_ret_req,
    input  logic            s_ret_req,
    input  logic            pipe_empty,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            s_eie,
    input  logic            s_tie,
    input  logic            m_interrupt,
    input  logic            s_interrupt,
    input  logic            m_timer,
    input  logic            s_timer,
    input  logic [XLEN-1:0] epc,
    output logic            exception_pending,
    output logic [XLEN-1:0] m_cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            m_ret,
    output logic            s_ret,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
`ifdef TRAP_SEQ_PERF_EN
    output logic [31:0]     trap_count,
    output logic [31:0]     irq_count,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam logic [3:0] c_drain_last = 4'(DRAIN_MAX - 1);
    localparam logic [4:0] c_code_mei   = 5'd11;
    localparam logic [4:0] c_code_mti   = 5'd7;
    localparam logic [4:0] c_code_sei   = 5'd9;
    localparam logic [4:0] c_code_sti   = 5'd5;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [XLEN-1:0]   r_cause;

    logic              w_mei;
    logic              w_mti;
    logic              w_sei;
    logic              w_sti;
    logic              w_irq_any;
    logic [4:0]        w_irq_code;
    logic [XLEN-1:0]   w_irq_cause;
    logic [XLEN-1:0]   w_exc_cause;

    assign w_mei     = m_interrupt & m_eie;
    assign w_mti     = m_timer     & m_tie;
    assign w_sei     = s_interrupt & s_eie;
    assign w_sti     = s_timer     & s_tie;
    assign w_irq_any = w_mei | w_mti | w_sei | w_sti;

    // Fixed interrupt priority MEI > MTI > SEI > STI.
    always_comb begin
        w_irq_code = c_code_sti;
        if (w_mei) begin
            w_irq_code = c_code_mei;
        end else if (w_mti) begin
            w_irq_code = c_code_mti;
        end else if (w_sei) begin
            w_irq_code = c_code_sei;
        end
    end

    assign w_irq_cause = {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
    assign w_exc_cause = {{(XLEN-5){1'b0}}, exc_cause};

    // Stall and busy decode state directly so the front end freezes in the
    // same cycle the sequencer leaves IDLE.
    assign busy  = (r_state != ST_IDLE);
    assign stall = (r_state == ST_DRAIN) || (r_state == ST_COMMIT) ||
                   (r_state == ST_REDIRECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_cnt             <= 4'd0;
            r_cause           <= '0;
            exception_pending <= 1'b0;
            m_cause           <= '0;
            pc_exc            <= '0;
            m_ret             <= 1'b0;
            s_ret             <= 1'b0;
            flush             <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
        end else begin
            // Strobes default low; each asserts only for the cycle entered.
            exception_pending <= 1'b0;
            flush             <= 1'b0;
            m_ret             <= 1'b0;
            s_ret             <= 1'b0;
            redirect_valid    <= 1'b0;
            m_cause           <= '0;
            pc_exc            <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        r_cause           <= w_exc_cause;
                        exception_pending <= 1'b1;
                        flush             <= 1'b1;
                        m_cause           <= w_exc_cause;
                        pc_exc            <= exc_pc;
                        r_state           <= ST_COMMIT;
                    end else if (m_ret_req) begin
                        // MRET wins over a simultaneous SRET.
                        exception_pending <= 1'b1;
                        flush             <= 1'b1;
                        m_ret             <= 1'b1;
                        r_state           <= ST_COMMIT;
                    end else if (s_ret_req) begin
                        exception_pending <= 1'b1;
                        flush             <= 1'b1;
                        s_ret             <= 1'b1;
                        r_state           <= ST_COMMIT;
                    end else if (w_irq_any) begin
                        r_cause <= w_irq_cause;
                        r_cnt   <= 4'd0;
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (exc_valid) begin
                        // The exception replaces the interrupt; a still-pending
                        // interrupt level is picked up again from IDLE.
                        r_cause           <= w_exc_cause;
                        exception_pending <= 1'b1;
                        flush             <= 1'b1;
                        m_cause           <= w_exc_cause;
                        pc_exc            <= exc_pc;
                        r_state           <= ST_COMMIT;
                    end else if (pipe_empty || (r_cnt == c_drain_last)) begin
                        exception_pending <= 1'b1;
                        flush             <= 1'b1;
                        m_cause           <= r_cause;
                        pc_exc            <= retire_pc;
                        r_state           <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    // epc is combinational on m_ret/s_ret in csr_regfile, so
                    // this capture yields xepc for a return, mtvec otherwise.
                    redirect_pc    <= epc;
                    redirect_valid <= 1'b1;
                    r_state        <= ST_REDIRECT;
                end

                ST_REDIRECT: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TRAP_SEQ_PERF_EN
    // m_ret/s_ret/m_cause are the registered COMMIT-cycle values, so they
    // identify the trap currently being committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_count <= 32'd0;
            irq_count  <= 32'd0;
        end else if ((r_state == ST_COMMIT) && !m_ret && !s_ret) begin
            trap_count <= trap_count + 32'd1;
            if (m_cause[XLEN-1]) begin
                irq_count <= irq_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
